fma_sequencer: RTL and testbench
================================

FMA_SEQUENCER -- requirements
Module: fma_sequencer

Interface
REQ-001 SHALL have parameter STAGE_TIMEOUT, default 15, giving the max cycles a stage may wait for its done (used only with FMA_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1: operand handshake.
REQ-005 SHALL have ports op_a, op_b, op_c  input  16 each: FP16 operands, result = a*b+c.
REQ-006 SHALL have ports mul_start output 1, mul_done input 1: multiplier stage handshake.
REQ-007 SHALL have ports add_start output 1, add_done input 1: align/add stage handshake.
REQ-008 SHALL have ports rounder_start output 1, rounder_done input 1: normalizer/rounder handshake.
REQ-009 SHALL have port fma_byp  output  1  rounder bypass select.
REQ-010 SHALL have ports rnd_sign input 1, rnd_exp input 5, rnd_mant input 10: rounder result fields.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, result output 16: result handshake.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_err  output  1  sticky stage-timeout flag (constant 0 without macro).

Function
REQ-014 SHALL implement states IDLE, MUL, ADD, RND, OUT; in_ready = (state==IDLE).
REQ-015 SHALL latch op_a/op_b/op_c on in_valid&in_ready; operands are not sampled otherwise.
REQ-016 SHALL classify latched operands on accept: special = any exponent field 5'h1F; zprod = op_a or op_b exponent and mantissa both zero.
REQ-017 On accept: special -> OUT with result 16'h7E00; zprod -> RND with fma_byp=1; else -> MUL.
REQ-018 SHALL pulse mul_start, add_start, rounder_start high exactly one cycle, the first cycle in MUL, ADD, RND respectively.
REQ-019 SHALL sample mul_done/add_done/rounder_done in the matching state only, including the start cycle; done seen -> next state on following edge (MUL->ADD->RND->OUT).
REQ-020 Done inputs outside their matching state SHALL be ignored.
REQ-021 fma_byp SHALL be held constant from accept through OUT exit; 0 on normal path.
REQ-022 On rounder_done in RND, result SHALL register {rnd_sign, rnd_exp, rnd_mant}.
REQ-023 out_valid SHALL be high exactly in OUT; result stable while out_valid&~out_ready.
REQ-024 On out_valid&out_ready -> IDLE; new operands accepted no earlier than the next cycle.
REQ-025 Minimum normal latency: out_valid 4 cycles after accept edge (done returned in start cycle); bypass 2; special 1.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, all start pulses 0, fma_byp 0, out_valid 0, result 16'h0000, busy 0, timeout_err 0, timeout counter 0.
REQ-027 Reset mid-operation SHALL abandon the operation with no output; pending done inputs after release are ignored (state IDLE).

Configuration
REQ-028 With FMA_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entry to MUL/ADD/RND and increment each cycle without done; reaching STAGE_TIMEOUT sets timeout_err (sticky until reset) and moves to OUT with result 16'h7E00.
REQ-029 Without FMA_SEQ_TIMEOUT_EN, no counter SHALL exist, stages wait indefinitely, timeout_err tied 0.

Structure
REQ-030 FP16 field widths, 16'h7E00 qNaN constant and state encoding SHALL live in shared package fma_pkg.
REQ-031 Operand classification SHALL be sub-module fma_operand_classifier (combinational, outputs special and zprod).

Verification
REQ-032 a=3C00, b=4000, c=3C00, all dones in start cycle -> mul/add/rounder_start pulses on cycles +1/+2/+3, out_valid at +4, result = rounder fields.
REQ-033 a=0000, b=4000, c=3C00 -> no mul/add start, fma_byp=1, rounder_start at +1, out_valid at +2.
REQ-034 a=7C00 -> no start pulses, out_valid at +1, result 7E00, fma_byp=0.
REQ-035 out_ready low 5 cycles in OUT -> result/out_valid stable, in_ready 0, and in_valid ignored throughout.
REQ-036 rst_n low during ADD -> outputs zero immediately; late add_done after release has no effect.
REQ-037 With FMA_SEQ_TIMEOUT_EN, STAGE_TIMEOUT=4, mul_done never asserted -> timeout_err=1 and result 7E00 after 4 MUL cycles.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared FP16 field layout, canonical quiet-NaN constant and sequencer state encoding.
package fma_pkg;

  localparam int FP_W   = 16;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int MAG_W  = FP_W - 1;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
  localparam logic [FP_W-1:0]  QNAN    = 16'h7E00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    ADD  = 3'd2,
    RND  = 3'd3,
    OUT  = 3'd4
  } state_e;

endpackage

// File: rtl/fma_operand_classifier.sv
// Combinational FP16 operand classifier: flags Inf/NaN operands and a zero product.
module fma_operand_classifier
  import fma_pkg::*;
(
  input  logic [MAG_W-1:0] a_mag,
  input  logic [MAG_W-1:0] b_mag,
  input  logic [EXP_W-1:0] c_exp,
  output logic             special,
  output logic             zprod
);

  logic a_special;
  logic b_special;
  logic c_special;

  assign a_special = (a_mag[MAG_W-1 -: EXP_W] == EXP_MAX);
  assign b_special = (b_mag[MAG_W-1 -: EXP_W] == EXP_MAX);
  assign c_special = (c_exp == EXP_MAX);

  // Sign is ignored so that -0 also short-circuits the multiplier.
  assign special = a_special | b_special | c_special;
  assign zprod   = (a_mag == '0) | (b_mag == '0);

endmodule

// File: rtl/fma_sequencer.sv
// Control sequencer for a three-stage FP16 fused multiply-add (a*b+c).
// Optional per-stage watchdog is compiled in when FMA_SEQ_TIMEOUT_EN is defined.
module fma_sequencer
  import fma_pkg::*;
#(
  parameter int STAGE_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   op_a,
  input  logic [FP_W-1:0]   op_b,
  input  logic [FP_W-1:0]   op_c,
  output logic              mul_start,
  input  logic              mul_done,
  output logic              add_start,
  input  logic              add_done,
  output logic              rounder_start,
  input  logic              rounder_done,
  output logic              fma_byp,
  input  logic              rnd_sign,
  input  logic [EXP_W-1:0]  rnd_exp,
  input  logic [MANT_W-1:0] rnd_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   result,
  output logic              busy,
  output logic              timeout_err
);

  state_e          state;
  state_e          next_state;
  logic            stage_first;
  logic            accept;
  logic            special;
  logic            zprod;
  logic            stage_wait;
  logic            timeout_hit;
  logic [FP_W-1:0] a_q;
  logic [FP_W-1:0] b_q;
  logic [FP_W-1:0] c_q;
  logic [FP_W-1:0] a_d;
  logic [FP_W-1:0] b_d;
  logic [FP_W-1:0] c_d;

  assign accept = in_valid & in_ready;

  // The classifier looks at the operand registers' next value so the
  // routing decision is available on the accept edge itself.
  assign a_d = accept ? op_a : a_q;
  assign b_d = accept ? op_b : b_q;
  assign c_d = accept ? op_c : c_q;

  fma_operand_classifier u_classify (
    .a_mag   (a_d[MAG_W-1:0]),
    .b_mag   (b_d[MAG_W-1:0]),
    .c_exp   (c_d[MAG_W-1 -: EXP_W]),
    .special (special),
    .zprod   (zprod)
  );

  assign stage_wait = ((state == MUL) & ~mul_done)
                    | ((state == ADD) & ~add_done)
                    | ((state == RND) & ~rounder_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (special) begin
            next_state = OUT;
          end else if (zprod) begin
            next_state = RND;
          end else begin
            next_state = MUL;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          next_state = ADD;
        end else if (timeout_hit) begin
          next_state = OUT;
        end
      end
      ADD: begin
        if (add_done) begin
          next_state = RND;
        end else if (timeout_hit) begin
          next_state = OUT;
        end
      end
      RND: begin
        if (rounder_done || timeout_hit) begin
          next_state = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Start strobes fire only on the first cycle of each stage.
  assign mul_start     = (state == MUL) & stage_first;
  assign add_start     = (state == ADD) & stage_first;
  assign rounder_start = (state == RND) & stage_first;
  assign in_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign out_valid     = (state == OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_first <= 1'b0;
      fma_byp     <= 1'b0;
      result      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
    end else begin
      stage_first <= (next_state != state);
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      if (accept) begin
        fma_byp <= zprod & ~special;
      end else if (out_valid && out_ready) begin
        fma_byp <= 1'b0;
      end
      if (accept && special) begin
        result <= QNAN;
      end else if ((state == RND) && rounder_done) begin
        result <= {rnd_sign, rnd_exp, rnd_mant};
      end else if (timeout_hit) begin
        result <= QNAN;
      end
    end
  end

`ifdef FMA_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(STAGE_TIMEOUT + 1);

  logic [CNT_W-1:0] stage_cnt;

  // The hit fires on the STAGE_TIMEOUT-th consecutive cycle without done.
  assign timeout_hit = stage_wait && (stage_cnt == CNT_W'(STAGE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (next_state != state) begin
        stage_cnt <= '0;
      end else if (stage_wait) begin
        stage_cnt <= stage_cnt + CNT_W'(1);
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_timeout = (STAGE_TIMEOUT != 0) | stage_wait;
`endif

endmodule

// File: tb/tb_fma_sequencer.sv
// Scoreboard testbench for fma_sequencer: stage timing, bypass paths, stalls, reset, timeout.
module tb_fma_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] op_c = '0;
  logic        mul_start;
  logic        mul_done = 1'b0;
  logic        add_start;
  logic        add_done = 1'b0;
  logic        rounder_start;
  logic        rounder_done = 1'b0;
  logic        fma_byp;
  logic        rnd_sign = 1'b0;
  logic [4:0]  rnd_exp = '0;
  logic [9:0]  rnd_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        busy;
  logic        timeout_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb[$];
  logic        exp_terr = 1'b0;

  // Stage responders: dones follow the start strobes unless held off.
  int   mul_delay = 0;
  int   mul_wait = 0;
  logic mul_pend = 1'b0;
  logic mul_en = 1'b1;
  logic add_en = 1'b1;
  logic spurious = 1'b0;

  fma_sequencer #(.STAGE_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_c          (op_c),
    .mul_start     (mul_start),
    .mul_done      (mul_done),
    .add_start     (add_start),
    .add_done      (add_done),
    .rounder_start (rounder_start),
    .rounder_done  (rounder_done),
    .fma_byp       (fma_byp),
    .rnd_sign      (rnd_sign),
    .rnd_exp       (rnd_exp),
    .rnd_mant      (rnd_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mul_start) begin
      mul_wait = mul_delay;
      mul_pend = 1'b1;
    end
    if (mul_pend && mul_en) begin
      if (mul_wait == 0) begin
        mul_done = 1'b1;
        mul_pend = 1'b0;
      end else begin
        mul_done = 1'b0;
        mul_wait--;
      end
    end else begin
      mul_done = spurious;
    end
  end

  always @(negedge clk) add_done = (add_start && add_en) || spurious;
  always @(negedge clk) rounder_done = rounder_start || spurious;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // One operation: drive operands, push the expected result, then time every strobe.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                               input logic [15:0] exp_res, input int exp_mul, input int exp_add,
                               input int exp_rnd, input int exp_lat, input logic exp_byp,
                               input int stall);
    int          mul_at;
    int          add_at;
    int          rnd_at;
    int          mul_n;
    int          add_n;
    int          rnd_n;
    int          out_at;
    logic        byp_bad;
    logic [15:0] want;
    mul_at = 0; add_at = 0; rnd_at = 0;
    mul_n = 0; add_n = 0; rnd_n = 0;
    out_at = 0; byp_bad = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_idle", in_ready, 1);
    op_a = a; op_b = b; op_c = c;
    in_valid = 1'b1;
    sb.push_back(exp_res);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = '0; op_b = '0; op_c = '0;
    for (int k = 1; k <= 40 && out_at == 0; k++) begin
      @(negedge clk);
      if (mul_start) begin mul_n++; if (mul_at == 0) mul_at = k; end
      if (add_start) begin add_n++; if (add_at == 0) add_at = k; end
      if (rounder_start) begin rnd_n++; if (rnd_at == 0) rnd_at = k; end
      if (fma_byp !== exp_byp) byp_bad = 1'b1;
      if (out_valid) out_at = k;
    end
    checkOutput("mul_start_cycle", mul_at, exp_mul);
    checkOutput("add_start_cycle", add_at, exp_add);
    checkOutput("rnd_start_cycle", rnd_at, exp_rnd);
    checkOutput("mul_start_pulses", mul_n, (exp_mul != 0) ? 1 : 0);
    checkOutput("add_start_pulses", add_n, (exp_add != 0) ? 1 : 0);
    checkOutput("rnd_start_pulses", rnd_n, (exp_rnd != 0) ? 1 : 0);
    checkOutput("fma_byp_held", byp_bad, 0);
    if (out_at == 0) begin
      checkOutput("out_valid_wait", 0, 1);
      void'(sb.pop_front());
    end else begin
      checkOutput("latency", out_at, exp_lat);
      want = sb.pop_front();
      checkOutput("result", result, want);
      checkOutput("timeout_err", timeout_err, exp_terr);
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'b1;
        op_a = 16'h7C00;
        @(negedge clk);
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_result", result, want);
        checkOutput("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      op_a = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_fma_byp", fma_byp, 0);
      checkOutput("idle_timeout_err", timeout_err, exp_terr);
    end
  endtask

  task automatic setRounder(input logic [15:0] v);
    {rnd_sign, rnd_exp, rnd_mant} = v;
  endtask

  // Abandon an operation in ADD with reset, then show a late add_done is ignored.
  task automatic resetMidOp();
    add_en = 1'b0;
    setRounder(16'h4500);
    @(negedge clk);
    op_a = 16'h4000; op_b = 16'h4200; op_c = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_add", add_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_result", result, 16'h0000);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_add_start", add_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    add_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("late_done_busy", busy, 0);
      checkOutput("late_done_out_valid", out_valid, 0);
      checkOutput("late_done_rnd_start", rounder_start, 0);
    end
    add_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;
    logic [15:0] rr;
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_result", result, 16'h0000);
    checkOutput("reset_fma_byp", fma_byp, 0);
    checkOutput("reset_starts", {mul_start, add_start, rounder_start}, 3'b000);
    checkOutput("reset_timeout_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1.0*2.0+1.0 on the full pipeline
    setRounder(16'h4200);
    applyStimulus(16'h3C00, 16'h4000, 16'h3C00, 16'h4200, 1, 2, 3, 4, 1'b0, 0);
    // zero product, both signs of zero
    setRounder(16'h3C00);
    applyStimulus(16'h0000, 16'h4000, 16'h3C00, 16'h3C00, 0, 0, 1, 2, 1'b1, 0);
    setRounder(16'hBC00);
    applyStimulus(16'h4000, 16'h8000, 16'hBC00, 16'hBC00, 0, 0, 1, 2, 1'b1, 0);
    // Inf/NaN operands go straight to OUT; special outranks a zero product
    setRounder(16'h1234);
    applyStimulus(16'h7C00, 16'h4000, 16'h3C00, 16'h7E00, 0, 0, 0, 1, 1'b0, 0);
    applyStimulus(16'h0000, 16'h4000, 16'hFE00, 16'h7E00, 0, 0, 0, 1, 1'b0, 0);
    // consumer stalls five cycles while new operands are offered
    setRounder(16'h4880);
    applyStimulus(16'h4000, 16'h4000, 16'h0400, 16'h4880, 1, 2, 3, 4, 1'b0, 5);
    // slow multiplier with stray add/rounder dones during MUL
    spurious = 1'b1;
    mul_delay = 3;
    setRounder(16'hC500);
    applyStimulus(16'hC000, 16'h4100, 16'h3800, 16'hC500, 1, 5, 6, 7, 1'b0, 0);
    spurious = 1'b0;
    mul_delay = 0;
    for (int i = 0; i < 4; i++) begin
      ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
      rc = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 30)), 10'($urandom)};
      rr = 16'($urandom);
      setRounder(rr);
      applyStimulus(ra, rb, rc, rr, 1, 2, 3, 4, 1'b0, i % 2);
    end

    resetMidOp();

`ifdef FMA_SEQ_TIMEOUT_EN
    mul_en = 1'b0;
    exp_terr = 1'b1;
    setRounder(16'h4400);
    applyStimulus(16'h3C00, 16'h4000, 16'h3C00, 16'h7E00, 1, 0, 0, 5, 1'b0, 0);
    mul_en = 1'b1;
`else
    mul_delay = 20;
    setRounder(16'h4400);
    applyStimulus(16'h3C00, 16'h4000, 16'h3C00, 16'h4400, 1, 22, 23, 24, 1'b0, 0);
    mul_delay = 0;
`endif

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
